// File: rtl/data_memory_wait_if.sv
// Request/response bus between the EX/MEM stage and the wait-state data memory.
interface data_memory_wait_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   write_data;
    logic [DATA_W/8-1:0] byte_en;
    logic                exmem_write;
    logic                exmem_read;
    logic [DATA_W-1:0]   memwb_readdata;
    logic                mem_busy;
    logic                mem_done;
    logic                dmem_error;

    modport master (
        output address, write_data, byte_en, exmem_write, exmem_read,
        input  memwb_readdata, mem_busy, mem_done, dmem_error
    );

    modport slave (
        input  address, write_data, byte_en, exmem_write, exmem_read,
        output memwb_readdata, mem_busy, mem_done, dmem_error
    );
endinterface

// File: rtl/data_memory_wait.sv
// Word-addressed RAM with byte strobes and programmable wait states behind a busy/done handshake.
// Optional out-of-range fault detector enabled by defining DMEM_ADDR_CHECK_EN.
module data_memory_wait #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    data_memory_wait_if.slave bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic              is_write;
        logic              is_read;
    } req_t;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    req_t               req_q, req_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [IDX_W-1:0]   idx_c;
    logic               addr_ok_c;

    assign idx_c = req_q.addr[IDX_W-1:0];

`ifdef DMEM_ADDR_CHECK_EN
    assign addr_ok_c = (req_q.addr < ADDR_W'(DEPTH));
`else
    // Upper address bits are ignored: the index wraps modulo DEPTH.
    logic unused_addr_hi;
    assign addr_ok_c      = 1'b1;
    assign unused_addr_hi = ^req_q.addr[ADDR_W-1:IDX_W];
`endif

    // State, request latch and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.exmem_read || bus.exmem_write) begin
                    req_d.addr     = bus.address;
                    req_d.wdata    = bus.write_data;
                    req_d.be       = bus.byte_en;
                    req_d.is_write = bus.exmem_write;
                    // Read+write together is a pure write.
                    req_d.is_read  = bus.exmem_read & ~bus.exmem_write;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (req_q.is_read) begin
                    rdata_d = addr_ok_c ? mem_q[idx_c] : '0;
                end
                err_d = err_q | ~addr_ok_c;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Storage is not reset; only lanes with a strobe set are written.
    always_ff @(posedge clk) begin
        if ((state_q == ST_ACCESS) && req_q.is_write && addr_ok_c) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (req_q.be[b]) begin
                    mem_q[idx_c][b*8 +: 8] <= req_q.wdata[b*8 +: 8];
                end
            end
        end
    end

    assign bus.memwb_readdata = rdata_q;
    assign bus.mem_done       = done_q;
    assign bus.mem_busy       = (state_q != ST_IDLE);
    assign bus.dmem_error     = err_q;

endmodule

// File: tb/tb_data_memory_wait.sv
// Self-checking bench for data_memory_wait: directed table, corner sequences, randomized model check.
module tb_data_memory_wait;
    localparam int unsigned W     = 2;
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    data_memory_wait_if #(.DATA_W(64), .ADDR_W(64)) bus ();

    data_memory_wait #(.DATA_W(64), .DEPTH(DEPTH), .ADDR_W(64), .WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

`ifdef DMEM_ADDR_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    // Reference model: plain word array, last read value and sticky fault.
    logic [63:0] mem_m [DEPTH];
    logic [63:0] rdata_m = '0;
    logic        err_m   = 1'b0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_apply(input logic rd, input logic wr, input logic [63:0] addr,
                               input logic [63:0] data, input logic [7:0] be);
        bit oob = CHK_EN && (addr >= 64'(DEPTH));
        int unsigned i = addr % DEPTH;
        if (oob) err_m = 1'b1;
        if (wr) begin
            if (!oob)
                for (int b = 0; b < 8; b++)
                    if (be[b]) mem_m[i][b*8 +: 8] = data[b*8 +: 8];
        end else if (rd) begin
            rdata_m = oob ? 64'd0 : mem_m[i];
        end
    endtask

    // Called one step after a rising edge with the DUT idle; returns in the done cycle.
    task automatic do_req(input string name, input logic rd, input logic wr,
                          input logic [63:0] addr, input logic [63:0] data, input logic [7:0] be,
                          input logic [63:0] exp_rdata, input logic exp_err);
        bus.exmem_read  = rd;
        bus.exmem_write = wr;
        bus.address     = addr;
        bus.write_data  = data;
        bus.byte_en     = be;
        @(posedge clk); #1;
        bus.exmem_read  = 1'b0;
        bus.exmem_write = 1'b0;
        bus.address     = '1;
        bus.write_data  = '1;
        bus.byte_en     = '1;
        for (int k = 0; k <= int'(W); k++) begin
            chk({name, "_busy"}, 64'(bus.mem_busy), 64'd1);
            chk({name, "_nodone"}, 64'(bus.mem_done), 64'd0);
            @(posedge clk); #1;
        end
        chk({name, "_idle"}, 64'(bus.mem_busy), 64'd0);
        chk({name, "_done"}, 64'(bus.mem_done), 64'd1);
        chk({name, "_rdata"}, bus.memwb_readdata, exp_rdata);
        chk({name, "_err"}, 64'(bus.dmem_error), 64'(exp_err));
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        chk("done_drop", 64'(bus.mem_done), 64'd0);
    endtask

    vec_t vecs [$];
    logic [63:0] exp_oob;
    logic [63:0] a, d;
    logic [7:0]  be;
    logic        rd, wr;
    int          ndone;

    initial begin
        rst_n           = 1'b0;
        bus.exmem_read  = 1'b0;
        bus.exmem_write = 1'b0;
        bus.address     = '0;
        bus.write_data  = '0;
        bus.byte_en     = '0;

        #3;
        chk("rst_rdata", bus.memwb_readdata, 64'd0);
        chk("rst_busy", 64'(bus.mem_busy), 64'd0);
        chk("rst_done", 64'(bus.mem_done), 64'd0);
        chk("rst_err", 64'(bus.dmem_error), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        exp_oob = CHK_EN ? 64'd0 : 64'h0000_0000_0000_A5A5;
        //          rd wr addr   data                     be     exp_rdata                 err
        vecs.push_back('{0, 1, 64'd5,    64'd100,                 8'hFF, 64'd0,                    1'b0});
        vecs.push_back('{1, 0, 64'd5,    64'd0,                   8'h00, 64'd100,                  1'b0});
        vecs.push_back('{0, 1, 64'd10,   64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd100,                  1'b0});
        vecs.push_back('{0, 1, 64'd10,   64'd0,                   8'h0F, 64'd100,                  1'b0});
        vecs.push_back('{1, 0, 64'd10,   64'd0,                   8'h00, 64'hFFFF_FFFF_0000_0000, 1'b0});
        vecs.push_back('{1, 1, 64'd3,    64'd200,                 8'hFF, 64'hFFFF_FFFF_0000_0000, 1'b0});
        vecs.push_back('{1, 0, 64'd3,    64'd0,                   8'h00, 64'd200,                  1'b0});
        vecs.push_back('{0, 1, 64'd10,   64'h1234,                8'h00, 64'd200,                  1'b0});
        vecs.push_back('{1, 0, 64'd10,   64'd0,                   8'h00, 64'hFFFF_FFFF_0000_0000, 1'b0});
        vecs.push_back('{0, 1, 64'd0,    64'hA5A5,                8'hFF, 64'hFFFF_FFFF_0000_0000, 1'b0});
        vecs.push_back('{1, 0, 64'd1024, 64'd0,                   8'h00, exp_oob,                  CHK_EN});
        vecs.push_back('{1, 0, 64'd5,    64'd0,                   8'h00, 64'd100,                  CHK_EN});

        foreach (vecs[i]) begin
            do_req($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                   vecs[i].data, vecs[i].be, vecs[i].exp_rdata, vecs[i].exp_err);
            model_apply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be);
        end
        idle_cycle();

        // Read of addr 7 re-asserted while busy must yield exactly one completion.
        do_req("pre7", 1'b0, 1'b1, 64'd7, 64'h7777, 8'hFF, rdata_m, err_m);
        model_apply(1'b0, 1'b1, 64'd7, 64'h7777, 8'hFF);
        bus.exmem_read = 1'b1;
        bus.address    = 64'd7;
        ndone          = 0;
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            if (k == int'(W)) bus.exmem_read = 1'b0;
            if (bus.mem_done) ndone++;
            @(posedge clk); #1;
        end
        chk("busy_ignore_ndone", 64'(ndone), 64'd1);
        model_apply(1'b1, 1'b0, 64'd7, 64'd0, 8'h00);
        chk("busy_ignore_rdata", bus.memwb_readdata, rdata_m);

        // Reset during WAIT of a store discards the store.
        do_req("pre12", 1'b0, 1'b1, 64'd12, 64'd9, 8'hFF, rdata_m, err_m);
        model_apply(1'b0, 1'b1, 64'd12, 64'd9, 8'hFF);
        bus.exmem_write = 1'b1;
        bus.address     = 64'd12;
        bus.write_data  = 64'd55;
        bus.byte_en     = 8'hFF;
        @(posedge clk); #1;
        bus.exmem_write = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk("midrst_busy", 64'(bus.mem_busy), 64'd0);
        chk("midrst_done", 64'(bus.mem_done), 64'd0);
        chk("midrst_rdata", bus.memwb_readdata, 64'd0);
        chk("midrst_err", 64'(bus.dmem_error), 64'd0);
        rdata_m = '0;
        err_m   = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_req("read12", 1'b1, 1'b0, 64'd12, 64'd0, 8'h00, 64'd9, 1'b0);
        model_apply(1'b1, 1'b0, 64'd12, 64'd0, 8'h00);

        // Randomized traffic over a small index pool, with aliased high address bits.
        for (int i = 0; i < 16; i++) begin
            d = {$urandom, $urandom};
            do_req("fill", 1'b0, 1'b1, 64'(i), d, 8'hFF, rdata_m, err_m);
            model_apply(1'b0, 1'b1, 64'(i), d, 8'hFF);
        end
        for (int i = 0; i < 60; i++) begin
            int unsigned op = $urandom_range(0, 2);
            rd = (op != 1);
            wr = (op != 0);
            a  = 64'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = a | (64'($urandom_range(1, 7)) << 10);
            d  = {$urandom, $urandom};
            be = 8'($urandom);
            model_apply(rd, wr, a, d, be);
            do_req($sformatf("rnd%0d", i), rd, wr, a, d, be, rdata_m, err_m);
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory_wait.md
# data_memory_wait

Parametrised successor to the pipelined core's data memory: a word-addressed RAM with per-byte write strobes, a programmable wait-state counter and a busy/done handshake that stalls the pipeline at the EX/MEM boundary. A request is latched on one clock edge, held for `WAIT_CYCLES` edges, then performed. Read data is registered into the MEM/WB path. An optional out-of-range detector reports an address fault to the status logic.

## Interface
- `DATA_W`, 64, data word width in bits; multiple of 8
- `DEPTH`, 1024, number of words
- `ADDR_W`, 64, address port width; address is a word index
- `WAIT_CYCLES`, 2, wait edges between acceptance and access; legal range 0..15
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `address`  in  ADDR_W  word index of the request
- `write_data`  in  DATA_W  store data
- `byte_en`  in  DATA_W/8  write lane strobes; bit i enables `write_data[8i+7:8i]`
- `exmem_write`  in  1  store request
- `exmem_read`  in  1  load request
- `memwb_readdata`  out  DATA_W  registered load result
- `mem_busy`  out  1  request in flight; pipeline must stall
- `mem_done`  out  1  one-cycle pulse on access completion
- `dmem_error`  out  1  sticky out-of-range fault (see Configuration)

## Operation
- FSM states: IDLE, WAIT, ACCESS.
- IDLE: at the rising edge where `exmem_read|exmem_write` = 1, latch `address`, `write_data`, `byte_en` and the op type.
  - If `WAIT_CYCLES` > 0, go to WAIT and set `cnt = WAIT_CYCLES-1`.
  - If `WAIT_CYCLES` = 0, go to ACCESS.
- WAIT: decrement `cnt` each edge. When `cnt` = 0, go to ACCESS.
- ACCESS, write: update only the lanes with `byte_en` set. Other lanes of the word are unchanged.
- ACCESS, read: load the full word into `memwb_readdata`.
- ACCESS always: set `mem_done`=1 and return to IDLE.
- `mem_busy` = (state != IDLE), decoded combinationally from state.
- Requests presented while `mem_busy`=1 are ignored. Inputs need not be held stable after acceptance.
- Read and write asserted together: treated as a write only. `memwb_readdata` is unchanged and one `mem_done` pulse is issued.
- Store with `byte_en`=0: no memory change; `mem_done` still pulses.
- `memwb_readdata` holds its value until the next completed read.
- Address width rule: with the error detector compiled out, the index is `address[$clog2(DEPTH)-1:0]`, i.e. it wraps modulo DEPTH. Upper bits are ignored.

## Timing
- Request accepted at edge N. Access occurs at edge N+1+`WAIT_CYCLES`.
- `mem_done` and new read data are visible in the cycle following the access edge.
- `mem_busy` is high from edge N until edge N+1+`WAIT_CYCLES` (i.e. `WAIT_CYCLES`+1 cycles).
- A new request may be presented in the cycle where `mem_done`=1; it is accepted at the next edge.
- Reset values: `memwb_readdata`=0, `mem_done`=0, `mem_busy`=0 (state IDLE), `dmem_error`=0, `cnt`=0.
- RAM contents are not reset.
- Reset asserted mid-request: the request is discarded and no write is performed, provided reset is asserted before the ACCESS edge.

## Configuration
- Macro: `DMEM_ADDR_CHECK_EN`.
- Defined: at ACCESS, an address >= DEPTH (full `ADDR_W` compare) suppresses the write. A read forces `memwb_readdata`=0. `dmem_error` is set and stays 1 until reset; `mem_done` still pulses.
- Undefined: addresses wrap modulo DEPTH and `dmem_error` is tied to 0.

## Test plan
- `WAIT_CYCLES`=2: write 100 to addr 5, accepted at edge N -> `mem_busy` high 3 cycles; `mem_done` pulses after edge N+3. Read addr 5 -> `memwb_readdata`=100 after edge N'+3.
- Byte strobes: write 0xFFFF_FFFF_FFFF_FFFF to addr 10 with `byte_en`=0xFF, then 0 with `byte_en`=0x0F -> read addr 10 = 0xFFFF_FFFF_0000_0000.
- Simultaneous read+write, addr 3, data 200 -> single `mem_done`; `memwb_readdata` unchanged. A following read of addr 3 returns 200.
- Request while busy: second read of addr 7 asserted during WAIT -> ignored; exactly one `mem_done`.
- `rst_n` pulled low during WAIT of a write of 55 to addr 12 (addr 12 pre-written with 9) -> outputs return to reset values; read of addr 12 returns 9.
- `DMEM_ADDR_CHECK_EN` defined, read addr 1024 -> `memwb_readdata`=0, `dmem_error`=1 and held. Without the macro, the same read returns the contents of addr 0.
